// File: rtl/router_pkg.sv
// Shared flit format and NI state encoding for the router network interface.
// Head payload layout is {dest, len} right-aligned in the payload field.
package router_pkg;
    localparam int PAYLOAD_W = 32;
    localparam int FLIT_SIZE = PAYLOAD_W + 3;

    // Non-zero codes so an idle (all-zero) flit never aliases a real type
    typedef enum logic [1:0] {
        NONE_FLIT = 2'b00,
        HEAD_FLIT = 2'b01,
        BODY_FLIT = 2'b10,
        TAIL_FLIT = 2'b11
    } FLIT_TYPE_t;

    typedef struct packed {
        logic                 valid;
        FLIT_TYPE_t           ftype;
        logic [PAYLOAD_W-1:0] payload;
    } FLIT_t;

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} NI_STATE_t;
endpackage

// File: rtl/ni_packetizer_if.sv
// Packet request, payload stream, flit output and credit return of the NI.
interface ni_packetizer_if #(
    parameter int MAX_LEN = 16,
    parameter int DEST_W  = 4
);
    import router_pkg::*;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic                 i_pkt_valid;
    logic                 o_pkt_ready;
    logic [DEST_W-1:0]    i_pkt_dest;
    logic [LEN_W-1:0]     i_pkt_len;
    logic                 i_data_valid;
    logic [PAYLOAD_W-1:0] i_data;
    logic                 o_data_ready;
    FLIT_t                o_flit;
    logic                 i_credit;
    logic                 o_pkt_sent;
    logic                 o_credit_err;

    modport slave (
        input  i_pkt_valid, i_pkt_dest, i_pkt_len, i_data_valid, i_data, i_credit,
        output o_pkt_ready, o_data_ready, o_flit, o_pkt_sent, o_credit_err
    );
    modport master (
        output i_pkt_valid, i_pkt_dest, i_pkt_len, i_data_valid, i_data, i_credit,
        input  o_pkt_ready, o_data_ready, o_flit, o_pkt_sent, o_credit_err
    );
endinterface

// File: rtl/credit_counter.sv
// Downstream buffer credit tracker; saturates at BUF_DEPTH and flags overflow.
module credit_counter #(
    parameter int BUF_DEPTH = 4,
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        // Simultaneous return and consume cancel out
        if (inc_i && !dec_i) begin
            if (count_q == CNT_W'(BUF_DEPTH)) err_d = 1'b1;
            else                              count_d = count_q + 1'b1;
        end else if (dec_i && !inc_i && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= CNT_W'(BUF_DEPTH);
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;
endmodule

// File: rtl/ni_packetizer.sv
// Network-interface packetizer: turns a (dest, len) request plus a payload word
// stream into head/body/tail flits, gated by downstream buffer credits.
module ni_packetizer import router_pkg::*; #(
    parameter int BUF_DEPTH = 4,
    parameter int MAX_LEN   = 16,
    parameter int DEST_W    = 4
) (
    input logic           clk,
    input logic           reset_n,
    ni_packetizer_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    NI_STATE_t         state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    FLIT_t             flit_q, flit_d;
    logic              sent_q, sent_d;
    logic              emit, data_rdy, has_credit, credit_err;
    logic [CNT_W-1:0]  credits;

    credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (bus.i_credit),
        .dec_i   (emit),
        .count_o (credits),
        .err_o   (credit_err)
    );

    assign has_credit = (credits != '0);

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        len_d    = len_q;
        rem_d    = rem_q;
        flit_d   = '0;
        sent_d   = 1'b0;
        emit     = 1'b0;
        data_rdy = (state_q == BODY || state_q == TAIL) && has_credit;
        unique case (state_q)
            IDLE: begin
                if (bus.i_pkt_valid) begin
                    dest_d  = bus.i_pkt_dest;
                    // A zero-length request still carries one word
                    len_d   = (bus.i_pkt_len == '0) ? LEN_W'(1) : bus.i_pkt_len;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (has_credit) begin
                    emit           = 1'b1;
                    flit_d.valid   = 1'b1;
                    flit_d.ftype   = HEAD_FLIT;
                    flit_d.payload = PAYLOAD_W'({dest_q, len_q});
                    if (len_q > LEN_W'(1)) begin
                        state_d = BODY;
                        rem_d   = len_q;
                    end else begin
                        state_d = TAIL;
                    end
                end
            end
            BODY: begin
                if (data_rdy && bus.i_data_valid) begin
                    emit           = 1'b1;
                    flit_d.valid   = 1'b1;
                    flit_d.ftype   = BODY_FLIT;
                    flit_d.payload = bus.i_data;
                    rem_d          = rem_q - 1'b1;
                    if (rem_q == LEN_W'(2)) state_d = TAIL;
                end
            end
            TAIL: begin
                if (data_rdy && bus.i_data_valid) begin
                    emit           = 1'b1;
                    flit_d.valid   = 1'b1;
                    flit_d.ftype   = TAIL_FLIT;
                    flit_d.payload = bus.i_data;
                    sent_d         = 1'b1;
                    state_d        = IDLE;
                    dest_d         = '0;
                    len_d          = '0;
                    rem_d          = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dest_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            flit_q  <= '0;
            sent_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            flit_q  <= flit_d;
            sent_q  <= sent_d;
        end
    end

    assign bus.o_pkt_ready  = (state_q == IDLE);
    assign bus.o_data_ready = data_rdy;
    assign bus.o_flit       = flit_q;
    assign bus.o_pkt_sent   = sent_q;
    assign bus.o_credit_err = credit_err;
endmodule
